bridge_uart_tx: RTL and testbench
=================================

# bridge_uart_tx

Memory-mapped serial transmitter peripheral that sits on the system bridge as a device slot alongside the timers. It is the responder on the processor bus: it accepts word writes and combinational reads from the bridge, buffers bytes in a FIFO, and serializes them on a single `tx` line as 8N1 frames. It raises a level interrupt toward the CPU when transmission drains.

## Interface
- `FIFO_DEPTH`, default 8: byte FIFO entries; must be a power of two, at least 2.
- `DIV_RESET`, default 16: reset value of the DIVISOR register, in clocks per bit.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Addr`  in  30  word address `[31:2]` from the bridge; only `Addr[3:2]` is decoded.
- `WE`  in  1  write strobe from the bridge, already qualified by device select.
- `Din`  in  32  write data.
- `Dout`  out  32  read data, combinational from `Addr`.
- `IRQ`  out  1  level interrupt.
- `tx`  out  1  serial output, idle high.

## Operation
- Register map, selected by `Addr[3:2]`:
  - 0 DATA: write pushes `Din[7:0]`; reads return 0.
  - 1 STATUS: read-only except bit 3.
    - [0] busy (FSM not IDLE), [1] empty, [2] full, [3] overflow (sticky), [15:8] FIFO count, other bits 0.
    - Any write to STATUS clears overflow.
  - 2 CTRL: [0] en, [1] ie; other bits read 0.
  - 3 DIVISOR: [15:0] clocks per bit; upper bits read 0. A stored value of 0 behaves as 1.
- FIFO push (DATA write):
  - Accepted if not full, or if full and a pop occurs in the same cycle (count unchanged in that case).
  - Otherwise the byte is dropped and overflow is set.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if en and the FIFO is not empty, pop into the shift register, load the bit counter with DIVISOR−1, go to START.
  - START: `tx`=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts DIVISOR cycles. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for DIVISOR cycles. At the end, if en and the FIFO is not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Clearing en mid-frame: the current frame completes and no further pop occurs.
- DIVISOR writes mid-frame take effect at the next bit-counter reload.
- IRQ = ie & empty & (state==IDLE). It is registered and changes one edge after the condition changes.
- Reset (`reset`=0, asynchronous):
  - FIFO empty, pointers 0, overflow 0, CTRL 0, DIVISOR=DIV_RESET, state IDLE.
  - `tx`=1, `IRQ`=0.
  - `Dout` at STATUS reads 0x00000002.
  - A reset mid-frame forces `tx` high immediately.

## Timing
- Register write performed at edge k is visible on `Dout` from cycle k+1.
- DATA write at edge k with en=1, FSM idle: count=1 after edge k; pop at edge k+1; `tx` falls after edge k+1.
- Frame length is exactly 10×DIVISOR cycles. Back-to-back frames have no gap.
- busy deasserts at the edge ending STOP. IRQ rises one edge later.
- `Dout` has no read side effects. Reads and writes in the same cycle return the pre-write value.
- FIFO count is 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

## Test plan
- Reset, then read STATUS → 0x00000002; `tx`=1; `IRQ`=0; read DIVISOR → 16.
- DIVISOR=4, CTRL=0x1, write DATA 0xA5:
  - `tx` is low for 4 cycles starting the cycle after the pop.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then stop high for 4 cycles; total 40 cycles.
- CTRL=0, write 9 bytes with FIFO_DEPTH=8:
  - STATUS → full=1, count=8, overflow=1.
  - A STATUS write clears overflow; count stays 8.
- DIVISOR=2, CTRL=0x3, write 3 bytes:
  - Three contiguous 20-cycle frames with no idle high between stop and start.
  - IRQ rises exactly one cycle after the final stop ends.
- FIFO full while a STOP-end pop coincides with a DATA write: write accepted, count unchanged, overflow stays 0.
- Assert `reset` low during bit 3 of a frame: `tx` goes high asynchronously; after release, STATUS=0x00000002 and no residual frame is sent.

Source files
------------

// File: rtl/bridge_uart_tx.sv
// Memory-mapped 8N1 serial transmitter for the system bridge.
// A byte FIFO feeds a START/DATA/STOP serializer; a level IRQ flags an idle, drained transmitter.
module bridge_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          en;
  logic          ie;
  logic [15:0]   divisor;

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          irq_q;

  logic [1:0]    sel;
  logic          wr_data;
  logic          wr_stat;
  logic          wr_ctrl;
  logic          wr_div;
  logic          empty;
  logic          full;
  logic          busy;
  logic          pop;
  logic          push_ok;
  logic [15:0]   div_eff;
  logic [15:0]   reload;
  logic          unused_bits;

  assign sel     = Addr[1:0];
  assign wr_data = WE && (sel == 2'd0);
  assign wr_stat = WE && (sel == 2'd1);
  assign wr_ctrl = WE && (sel == 2'd2);
  assign wr_div  = WE && (sel == 2'd3);

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign busy    = (state_q != S_IDLE);
  // A full FIFO still takes a byte when a pop frees a slot on the same edge.
  assign push_ok = wr_data && (!full || pop);

  assign div_eff = (divisor == '0) ? 16'd1 : divisor;
  assign reload  = div_eff - 16'd1;

  assign unused_bits = ^{Addr[29:2], Din[31:16]};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= Din[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_data && !push_ok) begin
        overflow <= 1'b1;
      end else if (wr_stat) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      divisor <= 16'(DIV_RESET);
    end else begin
      if (wr_ctrl) begin
        en <= Din[0];
        ie <= Din[1];
      end
      if (wr_div) begin
        divisor <= Din[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= ie && empty && (state_q == S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          cnt_d   = reload;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = reload;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = reload;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next frame so there is no idle bit between frames.
          if (en && !empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            cnt_d   = reload;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the next state so tx stays glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    Dout = '0;
    case (sel)
      2'd1: begin
        Dout[0]    = busy;
        Dout[1]    = empty;
        Dout[2]    = full;
        Dout[3]    = overflow;
        Dout[15:8] = 8'(count);
      end
      2'd2:    Dout[1:0]  = {ie, en};
      2'd3:    Dout[15:0] = divisor;
      default: Dout = '0;
    endcase
  end

  assign tx  = tx_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_bridge_uart_tx.sv
// Directed bench for bridge_uart_tx: register map, frame waveforms, FIFO limits, IRQ and reset.
// Written bytes go to a scoreboard queue; a line monitor decodes frames and checks them in order.
module tb_bridge_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        tx;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sb[$];
  logic        exp_wave[$];
  int unsigned mon_div = 4;
  logic        mon_en  = 1'b0;

  always #5 clk = ~clk;

  bridge_uart_tx #(
    .FIFO_DEPTH(8),
    .DIV_RESET (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ),
    .tx   (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'($urandom()), a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'($urandom()), a};
    #1;
    d = Dout;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic add_frame(input logic [7:0] b, input int unsigned d);
    logic v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat (d) exp_wave.push_back(v);
    end
  endtask

  // Current negedge is sample index 'first'; returns at sample index exp_wave.size().
  task automatic check_wave(input int first, input string tag);
    for (int j = first; j < exp_wave.size(); j++) begin
      chk($sformatf("%s[%0d]", tag, j), {31'b0, tx}, {31'b0, exp_wave[j]});
      @(negedge clk);
    end
  endtask

  // Line monitor: mid-bit sampling of each frame, popped against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        int unsigned d;
        logic [7:0]  got;
        logic        start_b;
        logic        stop_b;
        d = mon_div;
        repeat (d / 2) @(negedge clk);
        start_b = tx;
        for (int b = 0; b < 8; b++) begin
          repeat (d) @(negedge clk);
          got[b] = tx;
        end
        repeat (d) @(negedge clk);
        stop_b = tx;
        chk("mon_start", {31'b0, start_b}, 32'd0);
        chk("mon_stop", {31'b0, stop_b}, 32'd1);
        n_tests++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_extra: observed frame %h expected none", got);
        end
        if (sb.size() > 0) chk("mon_frame", {24'b0, got}, {24'b0, sb.pop_front()});
        repeat (d - d / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time %0t expected earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic        done;
    int          lows;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_reg("rst_status", 2'd1, 32'h0000_0002);
    chk_reg("rst_div", 2'd3, 32'd16);
    chk_reg("rst_ctrl", 2'd2, 32'd0);
    chk_reg("rst_data", 2'd0, 32'd0);

    // Single 0xA5 frame at DIVISOR=4, checked cycle by cycle
    wr(2'd3, 32'd4);
    chk_reg("div4", 2'd3, 32'd4);
    mon_div = 4;
    mon_en  = 1'b1;
    wr(2'd2, 32'd1);
    sb.push_back(8'hA5);
    wr(2'd0, 32'h0000_01A5);
    chk_reg("push_count1", 2'd1, 32'h0000_0100);
    @(negedge clk);
    chk_reg("pop_busy", 2'd1, 32'h0000_0003);
    exp_wave.delete();
    add_frame(8'hA5, 4);
    check_wave(0, "a5");
    chk_reg("a5_idle", 2'd1, 32'h0000_0002);
    chk("a5_irq", {31'b0, IRQ}, 32'd0);

    // Read in the write cycle returns the old value; upper DIVISOR bits read 0
    Addr = {28'($urandom()), 2'd3};
    Din  = 32'hFFFF_0002;
    WE   = 1'b1;
    #1;
    chk("rd_during_wr", Dout, 32'd4);
    @(negedge clk);
    WE = 1'b0;
    chk_reg("div_mask", 2'd3, 32'd2);
    wr(2'd2, 32'd0);

    // Nine writes into an 8-deep FIFO with transmit disabled
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(8'(8'h10 + i));
      wr(2'd0, 32'h10 + 32'(i));
    end
    chk_reg("ovf_full", 2'd1, 32'h0000_080C);
    wr(2'd1, 32'hFFFF_FFFF);
    chk_reg("ovf_clear", 2'd1, 32'h0000_0804);

    // Full FIFO: push coinciding with IDLE pop, then with STOP-end pop
    mon_div = 2;
    wr(2'd2, 32'd1);
    sb.push_back(8'h80);
    wr(2'd0, 32'h80);
    chk_reg("idle_pop_push", 2'd1, 32'h0000_0805);
    repeat (19) @(negedge clk);
    chk_reg("pre_stop_full", 2'd1, 32'h0000_0805);
    sb.push_back(8'h81);
    wr(2'd0, 32'h81);
    chk_reg("stop_pop_push", 2'd1, 32'h0000_0805);

    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      rd(2'd1, v);
      if (v == 32'h0000_0002) done = 1'b1;
      else @(negedge clk);
    end
    chk("drain", {31'b0, done}, 32'd1);

    // Three back-to-back frames at DIVISOR=2 with interrupt enabled
    wr(2'd2, 32'hFFFF_FFFF);
    chk("irq_lag", {31'b0, IRQ}, 32'd0);
    chk_reg("ctrl_mask", 2'd2, 32'd3);
    @(negedge clk);
    chk("irq_idle", {31'b0, IRQ}, 32'd1);
    exp_wave.delete();
    add_frame(8'h55, 2);
    add_frame(8'hC3, 2);
    add_frame(8'h0F, 2);
    sb.push_back(8'h55);
    sb.push_back(8'hC3);
    sb.push_back(8'h0F);
    wr(2'd0, 32'h55);
    wr(2'd0, 32'hC3);
    wr(2'd0, 32'h0F);
    chk("irq_busy", {31'b0, IRQ}, 32'd0);
    check_wave(1, "b2b");
    chk_reg("b2b_idle", 2'd1, 32'h0000_0002);
    chk("irq_at_stop_end", {31'b0, IRQ}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'b0, IRQ}, 32'd1);

    // Reset asserted during data bit 3
    mon_en = 1'b0;
    wr(2'd3, 32'd4);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'hF0);
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("bit3_low", {31'b0, tx}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_tx", {31'b0, tx}, 32'd1);
    chk("async_irq", {31'b0, IRQ}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk_reg("post_rst_status", 2'd1, 32'h0000_0002);
    chk_reg("post_rst_div", 2'd3, 32'd16);
    chk_reg("post_rst_ctrl", 2'd2, 32'd0);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_residual", 32'(lows), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
